// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter steering four valid/ready sources through a shared 4:1 mux
// into one registered valid/ready output channel.
module mux_4_1_rr_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       up_valid,
    input  logic [WIDTH-1:0] up_data0,
    input  logic [WIDTH-1:0] up_data1,
    input  logic [WIDTH-1:0] up_data2,
    input  logic [WIDTH-1:0] up_data3,
    output logic [3:0]       up_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_sel_q, out_sel_d;
    logic [1:0]       ptr_q, ptr_d;

    logic             load;
    logic             gnt_found;
    logic [1:0]       gnt_idx;
    logic [1:0]       idx;
    logic [WIDTH-1:0] mux_data;

    assign load = !out_valid_q || out_ready;

    // Search starts one past the last granted source; 2-bit add wraps mod 4.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        idx       = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!gnt_found && up_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    always_comb begin
        mux_data = up_data0;
        unique case (gnt_idx)
            2'd0: mux_data = up_data0;
            2'd1: mux_data = up_data1;
            2'd2: mux_data = up_data2;
            2'd3: mux_data = up_data3;
            default: mux_data = up_data0;
        endcase
    end

    always_comb begin
        up_ready = 4'b0000;
        if (!rst && load && gnt_found) begin
            up_ready = 4'b0001 << gnt_idx;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (gnt_found) begin
                out_valid_d = 1'b1;
                out_data_d  = mux_data;
                out_sel_d   = gnt_idx;
                ptr_d       = gnt_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
            ptr_q       <= 2'd3;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Directed bench for mux_4_1_rr_arbiter: reference model plus in-order scoreboard
// of accepted words, checked with immediate assertions.
module tb_mux_4_1_rr_arbiter;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       up_valid;
    logic [WIDTH-1:0] d [4];
    logic [3:0]       up_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;

    mux_4_1_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (up_valid),
        .up_data0  (d[0]),
        .up_data1  (d[1]),
        .up_data2  (d[2]),
        .up_data3  (d[3]),
        .up_ready  (up_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       m_sel;
    logic [1:0]       m_ptr;
    logic [WIDTH+1:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called just after a rising edge with inputs already driven.
    task automatic cycle();
        logic             load;
        logic             found;
        logic [1:0]       g;
        logic [1:0]       j;
        logic [3:0]       exp_rdy;
        logic [WIDTH+1:0] front;
        #1;
        load  = !m_valid || out_ready;
        found = 1'b0;
        g     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            j = m_ptr + 2'(k);
            if (!found && up_valid[j]) begin
                found = 1'b1;
                g     = j;
            end
        end
        exp_rdy = (!rst && load && found) ? (4'b0001 << g) : 4'b0000;
        chk("up_ready", 32'(up_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        if (m_valid) chk("out_sel", 32'(out_sel), 32'(m_sel));
        if (!rst && m_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(1), 32'(0));
            end else begin
                front = sb.pop_front();
                chk("sb_word", 32'({out_sel, out_data}), 32'(front));
            end
        end
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 2'd0;
            m_ptr   = 2'd3;
            sb.delete();
        end else if (load) begin
            if (found) begin
                m_valid = 1'b1;
                m_data  = d[g];
                m_sel   = g;
                m_ptr   = g;
                sb.push_back({g, d[g]});
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        m_valid   = 1'b0;
        m_data    = '0;
        m_sel     = 2'd0;
        m_ptr     = 2'd3;
        rst       = 1'b1;
        up_valid  = 4'b1111;
        out_ready = 1'b1;
        d[0] = 4'hA; d[1] = 4'hB; d[2] = 4'hC; d[3] = 4'hD;
        @(posedge clk);
        #1;

        // Reset with every source requesting
        cycle();
        cycle();
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_sel", 32'(out_sel), 32'(0));
        rst = 1'b0;
        #1;
        chk("first_grant", 32'(up_ready), 32'(4'b0001));

        // Full contention: rotates 0,1,2,3,... one word per cycle
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("rr_sel", 32'(out_sel), 32'(k % 4));
            chk("rr_data", 32'(out_data), 32'(10 + k % 4));
        end

        // Backpressure while holding 0xB
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_data", 32'(out_data), 32'(4'hB));
            chk("bp_sel", 32'(out_sel), 32'(1));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(up_ready), 32'(4'b0100));
        cycle();
        chk("bp_next_data", 32'(out_data), 32'(4'hC));

        // Sparse: move ptr to 1 with a lone requester, then alternate 3,1,3
        up_valid = 4'b0010;
        cycle();
        chk("single_sel", 32'(out_sel), 32'(1));
        up_valid = 4'b1010;
        cycle();
        chk("sparse_sel0", 32'(out_sel), 32'(3));
        cycle();
        chk("sparse_sel1", 32'(out_sel), 32'(1));
        cycle();
        chk("sparse_sel2", 32'(out_sel), 32'(3));

        // Bubble: one word from source 2 then idle
        up_valid = 4'b0100;
        d[2] = 4'h5;
        cycle();
        up_valid = 4'b0000;
        chk("bubble_valid", 32'(out_valid), 32'(1));
        chk("bubble_data", 32'(out_data), 32'(4'h5));
        chk("bubble_sel", 32'(out_sel), 32'(2));
        cycle();
        chk("bubble_gone", 32'(out_valid), 32'(0));
        chk("bubble_hold", 32'(out_data), 32'(4'h5));
        cycle();

        // Reset while holding 0xC under backpressure
        d[2] = 4'hC;
        up_valid = 4'b0100;
        out_ready = 1'b0;
        cycle();
        up_valid = 4'b0000;
        cycle();
        chk("mid_hold", 32'(out_data), 32'(4'hC));
        rst = 1'b1;
        cycle();
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        rst = 1'b0;
        up_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("mid_first_grant", 32'(up_ready), 32'(4'b0001));
        cycle();
        chk("mid_first_sel", 32'(out_sel), 32'(0));

        // Drain
        up_valid = 4'b0000;
        cycle();
        cycle();
        chk("sb_empty", 32'(sb.size()), 32'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
